sram_mem_controller: RTL and testbench

Sequences the MEM-stage data access onto an external 16-bit asynchronous SRAM. Each 32-bit word takes two timed 16-bit transfers. The block drives `ready`; the pipeline top level derives `freeze = ~ready` for the IF, ID, EXE and MEM stage registers. It sits between the EXE stage register outputs (address = ALU result, write data = `val_Rm`, read/write enables) and the MEM/WB stage register.

---
 rtl/sram_mem_controller.sv | 142 ++++++++++++++
 tb/tb_sram_mem_controller.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_mem_controller.sv
// MEM-stage controller for a 16-bit asynchronous SRAM: each 32-bit word is two timed halfword
// transfers. Define SRAM_WRITE_POST_EN to add a single-entry posted-write buffer.
module sram_mem_controller #(
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned SRAM_ADDR_W = 18,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [15:0]            sram_dq_out,
  input  logic [15:0]            sram_dq_in,
  output logic                   sram_dq_oe,
  output logic                   sram_ce_n,
  output logic                   sram_oe_n,
  output logic                   sram_we_n,
  output logic                   sram_ub_n,
  output logic                   sram_lb_n
);

  localparam int unsigned WordW   = SRAM_ADDR_W - 1;
  localparam logic [3:0]  LastCnt = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StLow, StHigh, StDone} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              is_wr_q, is_wr_d;
  logic              posted_q, posted_d;
  logic [WordW-1:0]  word_q, word_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;

  logic [31:0]       off;
  logic [WordW-1:0]  word_in;
  logic              req, last, busy, hi;

  assign off     = address - BASE_ADDR;
  assign word_in = off[SRAM_ADDR_W:2];
  assign req     = rd_en | wr_en;
  assign last    = (cnt_q == LastCnt);
  assign busy    = (state_q == StLow) || (state_q == StHigh);
  assign hi      = (state_q == StHigh);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_wr_d  = is_wr_q;
    posted_d = posted_q;
    word_d   = word_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          state_d = StLow;
          cnt_d   = 4'd0;
          is_wr_d = wr_en;  // a simultaneous read+write is treated as a write
          word_d  = word_in;
          wdata_d = write_data;
`ifdef SRAM_WRITE_POST_EN
          posted_d = wr_en;
`else
          posted_d = 1'b0;
`endif
        end
      end
      StLow: begin
        if (last) begin
          if (!is_wr_q) rdata_d[15:0] = sram_dq_in;
          state_d = StHigh;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StHigh: begin
        if (last) begin
          if (!is_wr_q) rdata_d[31:16] = sram_dq_in;
          // Posted writes finish silently; the pipeline was never stalled for them.
          state_d = posted_q ? StIdle : StDone;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      is_wr_q  <= 1'b0;
      posted_q <= 1'b0;
      word_q   <= '0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_wr_q  <= is_wr_d;
      posted_q <= posted_d;
      word_q   <= word_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
    end
  end

  // Strobes decode straight from state so an async reset releases the bus at once.
  always_comb begin
    sram_addr   = busy ? {word_q, hi} : '0;
    sram_ce_n   = ~busy;
    sram_ub_n   = ~busy;
    sram_lb_n   = ~busy;
    sram_oe_n   = ~(busy & ~is_wr_q);
    sram_we_n   = ~(busy & is_wr_q & ~last);
    sram_dq_oe  = busy & is_wr_q;
    sram_dq_out = 16'd0;
    if (busy && is_wr_q) sram_dq_out = hi ? wdata_q[31:16] : wdata_q[15:0];
  end

  always_comb begin
`ifdef SRAM_WRITE_POST_EN
    ready = ((state_q == StIdle) && (!rd_en || wr_en)) || (state_q == StDone) ||
            (busy && posted_q && !req);
`else
    ready = ((state_q == StIdle) && !req) || (state_q == StDone);
`endif
  end

  assign read_data = rdata_q;

endmodule

// File: tb/tb_sram_mem_controller.sv
// Directed bench for sram_mem_controller with a behavioural 64-entry SRAM model.
// Default build checks stalled writes; with SRAM_WRITE_POST_EN it checks the posted-write path.
module tb_sram_mem_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en, wr_en;
  logic [31:0] address, write_data, read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

  always #5 clk = ~clk;

  sram_mem_controller dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready), .sram_addr(sram_addr),
    .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in), .sram_dq_oe(sram_dq_oe),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
  );

  logic [15:0] mem [64];
  assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[5:0]] : 16'h0000;
  always @(posedge clk) if (!sram_ce_n && !sram_we_n) mem[sram_addr[5:0]] <= sram_dq_out;

  // Bus monitor: logs we_n-low cycles and the halfword addresses touched.
  int          nw;
  logic [17:0] wa [8];
  logic [15:0] wd [8];
  logic        have_first;
  logic [17:0] first_addr, last_addr;
  int          oe_bad;
  always @(negedge clk) begin
    if (!sram_ce_n) begin
      if (!have_first) first_addr = sram_addr;
      have_first = 1'b1;
      last_addr  = sram_addr;
      if (sram_dq_oe !== sram_oe_n) oe_bad++;
      if (!sram_we_n && nw < 8) begin
        wa[nw] = sram_addr;
        wd[nw] = sram_dq_out;
        nw++;
      end
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic clear_log();
    nw = 0;
    have_first = 1'b0;
    oe_bad = 0;
  endtask

  // Raise a request and hold it until ready; returns stall cycles and read_data seen at ready.
  task automatic access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] rdat);
    rd_en = r; wr_en = w; address = a; write_data = d; lat = 0;
    @(negedge clk);
    while (!ready && lat < 50) begin
      lat++;
      @(negedge clk);
    end
    rdat = read_data;
    @(posedge clk); #1;
    rd_en = 1'b0; wr_en = 1'b0;
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [17:0] lo;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int          lat, cyc, phase;
    logic [31:0] rdat;
    logic        wr_any;

    vecs[0] = '{1'b0, 1'b1, 32'd1024,   32'hDEADBEEF, 18'h00000, 32'h00000000};
    vecs[1] = '{1'b1, 1'b0, 32'd1032,   32'h0,        18'h00004, 32'h12345678};
    vecs[2] = '{1'b0, 1'b1, 32'd1040,   32'hCAFEF00D, 18'h00008, 32'h12345678};
    vecs[3] = '{1'b1, 1'b1, 32'd1028,   32'hA5A55A5A, 18'h00002, 32'h12345678};
    vecs[4] = '{1'b0, 1'b1, 32'd1020,   32'h11112222, 18'h3FFFE, 32'h12345678};
    vecs[5] = '{1'b1, 1'b0, 32'd1024,   32'h0,        18'h00000, 32'hDEADBEEF};
    vecs[6] = '{1'b1, 1'b0, 32'd1028,   32'h0,        18'h00002, 32'hA5A55A5A};
    vecs[7] = '{1'b1, 1'b0, 32'd1020,   32'h0,        18'h3FFFE, 32'h11112222};
    vecs[8] = '{1'b1, 1'b0, 32'd525312, 32'h0,        18'h00000, 32'hDEADBEEF};
    vecs[9] = '{1'b1, 1'b0, 32'd1040,   32'h0,        18'h00008, 32'hCAFEF00D};

    for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
    mem[4] = 16'h5678;
    mem[5] = 16'h1234;
    clear_log();
    rd_en = 1'b0; wr_en = 1'b0; address = 32'd0; write_data = 32'd0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_rdata", read_data, 32'd0);
    chk("rst_we_n", 32'(sram_we_n), 32'd1);
    chk("rst_ce_n", 32'(sram_ce_n), 32'd1);
    chk("rst_oe_n", 32'(sram_oe_n), 32'd1);
    chk("rst_addr", 32'(sram_addr), 32'd0);
    chk("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
    @(posedge clk); #1;

`ifndef SRAM_WRITE_POST_EN
    for (int i = 0; i < 10; i++) begin
      clear_log();
      access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, lat, rdat);
      wr_any = vecs[i].wr;
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'd5);
      chk($sformatf("v%0d_rdata", i), rdat, vecs[i].exp_rd);
      chk($sformatf("v%0d_lo_addr", i), 32'(first_addr), 32'(vecs[i].lo));
      chk($sformatf("v%0d_hi_addr", i), 32'(last_addr), 32'(vecs[i].lo + 18'd1));
      chk($sformatf("v%0d_oe_mix", i), 32'(oe_bad), 32'd0);
      chk($sformatf("v%0d_we_cycles", i), 32'(nw), wr_any ? 32'd2 : 32'd0);
      if (wr_any && nw == 2) begin
        chk($sformatf("v%0d_w0_addr", i), 32'(wa[0]), 32'(vecs[i].lo));
        chk($sformatf("v%0d_w0_data", i), 32'(wd[0]), 32'(vecs[i].wdata[15:0]));
        chk($sformatf("v%0d_w1_addr", i), 32'(wa[1]), 32'(vecs[i].lo + 18'd1));
        chk($sformatf("v%0d_w1_data", i), 32'(wd[1]), 32'(vecs[i].wdata[31:16]));
      end
    end

    // Load followed immediately by a store from the next instruction.
    rd_en = 1'b1; address = 32'd1032; cyc = 0; phase = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cyc++;
      if (ready) begin
        if (phase == 0) begin
          chk("b2b_load_data", read_data, 32'h12345678);
          @(posedge clk); #1;
          rd_en = 1'b0; wr_en = 1'b1; address = 32'd1044; write_data = 32'h0BADF00D;
          phase = 1;
        end else begin
          break;
        end
      end
    end
    @(posedge clk); #1;
    wr_en = 1'b0;
    chk("b2b_cycles", 32'(cyc), 32'd12);
    chk("b2b_mem_lo", 32'(mem[10]), 32'h0000F00D);
    chk("b2b_mem_hi", 32'(mem[11]), 32'h00000BAD);
`else
    // Posted store: no stall; a following load waits for the background write.
    clear_log();
    wr_en = 1'b1; address = 32'd1024; write_data = 32'h13572468;
    @(negedge clk);
    chk("post_store_ready", 32'(ready), 32'd1);
    @(posedge clk); #1;
    wr_en = 1'b0;
    access(1'b1, 1'b0, 32'd1024, 32'h0, lat, rdat);
    chk("post_load_latency", 32'(lat), 32'd9);
    chk("post_load_data", rdat, 32'h13572468);
    chk("post_we_cycles", 32'(nw), 32'd2);
    chk("post_w0_data", 32'(wd[0]), 32'h00002468);
    chk("post_w1_data", 32'(wd[1]), 32'h00001357);
    wr_en = 1'b1; address = 32'd1028; write_data = 32'h2468ACE0;
    cyc = 0;
    @(negedge clk);
    if (ready) cyc++;
    @(posedge clk); #1;
    wr_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ready) cyc++;
    end
    chk("post_ready_held", 32'(cyc), 32'd7);
    chk("post_mem_lo", 32'(mem[2]), 32'h0000ACE0);
    chk("post_mem_hi", 32'(mem[3]), 32'h00002468);
    @(posedge clk); #1;
`endif

    // Reset in the middle of a write must drop the strobes without a clock edge.
    wr_en = 1'b1; address = 32'd1036; write_data = 32'h55AA55AA;
    cyc = 0;
    @(negedge clk);
    while (sram_we_n && cyc < 20) begin
      cyc++;
      @(negedge clk);
    end
    chk("mid_we_seen", 32'(sram_we_n), 32'd0);
    rst = 1'b1;
    #1;
    chk("mid_we_n", 32'(sram_we_n), 32'd1);
    chk("mid_ce_n", 32'(sram_ce_n), 32'd1);
    chk("mid_dq_oe", 32'(sram_dq_oe), 32'd0);
    chk("mid_addr", 32'(sram_addr), 32'd0);
    chk("mid_rdata", read_data, 32'd0);
    wr_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_ready_after", 32'(ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
